// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Shared constants and the FSM state type for the 12-element serializer.
// Ports: none (package).
// ---------------------------------------------------------------------------
package matrix_pkg;

  localparam int ELEM_W   = 8;   // default element width
  localparam int NUM_ELEM = 12;  // elements per frame
  localparam int SEL_W    = 4;   // width of the element index
  localparam int LAST_IDX = 11;  // index of the final element in a frame

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/mux_serializer12_if.sv
// ---------------------------------------------------------------------------
// mux_serializer12_if
// Groups the frame-input handshake and the element-output stream.
// Ports (signals):
//   in_valid/in_ready    frame handshake, in_data1..in_data12 frame elements
//   out_valid/out_ready  element handshake, out_data/out_sel/out_last element
//   busy                 a frame is being streamed
// Modports: master drives the frame and out_ready; slave is the serializer.
// ---------------------------------------------------------------------------
interface mux_serializer12_if
  import matrix_pkg::*;
#(
  parameter int DATA_W = ELEM_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic [DATA_W-1:0] in_data3;
  logic [DATA_W-1:0] in_data4;
  logic [DATA_W-1:0] in_data5;
  logic [DATA_W-1:0] in_data6;
  logic [DATA_W-1:0] in_data7;
  logic [DATA_W-1:0] in_data8;
  logic [DATA_W-1:0] in_data9;
  logic [DATA_W-1:0] in_data10;
  logic [DATA_W-1:0] in_data11;
  logic [DATA_W-1:0] in_data12;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_sel;
  logic              out_last;
  logic              busy;

  modport master (
    output in_valid, in_data1, in_data2, in_data3, in_data4, in_data5, in_data6,
           in_data7, in_data8, in_data9, in_data10, in_data11, in_data12,
           out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last, busy
  );

  modport slave (
    input  in_valid, in_data1, in_data2, in_data3, in_data4, in_data5, in_data6,
           in_data7, in_data8, in_data9, in_data10, in_data11, in_data12,
           out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last, busy
  );

endinterface

// File: rtl/mux12to1.sv
// ---------------------------------------------------------------------------
// mux12to1
// Combinational 12:1 element selector.
// Ports:
//   sel   in   SEL_W            element index 0..11
//   din   in   DATA_W x 12      element inputs, din[k] selected by sel==k
//   dout  out  DATA_W           selected element; zero for indices 12..15
// ---------------------------------------------------------------------------
module mux12to1
  import matrix_pkg::*;
#(
  parameter int DATA_W = ELEM_W
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] din [NUM_ELEM],
  output logic [DATA_W-1:0] dout
);

  // Element select; out-of-range indices yield zero rather than stale data.
  always_comb begin
    dout = '0;
    case (sel)
      4'd0:    dout = din[0];
      4'd1:    dout = din[1];
      4'd2:    dout = din[2];
      4'd3:    dout = din[3];
      4'd4:    dout = din[4];
      4'd5:    dout = din[5];
      4'd6:    dout = din[6];
      4'd7:    dout = din[7];
      4'd8:    dout = din[8];
      4'd9:    dout = din[9];
      4'd10:   dout = din[10];
      4'd11:   dout = din[11];
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/mux_serializer12.sv
// ---------------------------------------------------------------------------
// mux_serializer12
// Captures a 12-element frame in one cycle and streams it out one element
// per accepted beat, index 0 first, with valid/ready backpressure.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of mux_serializer12_if (frame in, element stream out)
// ---------------------------------------------------------------------------
module mux_serializer12
  import matrix_pkg::*;
#(
  parameter int DATA_W = ELEM_W
) (
  input logic                clk,
  input logic                rst_n,
  mux_serializer12_if.slave  bus
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [SEL_W-1:0]  idx_r;
  logic [SEL_W-1:0]  idx_nxt_s;
  logic              capture_s;
  logic              send_s;
  logic [DATA_W-1:0] bank_r    [NUM_ELEM];
  logic [DATA_W-1:0] in_elem_s [NUM_ELEM];
  logic [DATA_W-1:0] mux_data_s;

  assign in_elem_s[0]  = bus.in_data1;
  assign in_elem_s[1]  = bus.in_data2;
  assign in_elem_s[2]  = bus.in_data3;
  assign in_elem_s[3]  = bus.in_data4;
  assign in_elem_s[4]  = bus.in_data5;
  assign in_elem_s[5]  = bus.in_data6;
  assign in_elem_s[6]  = bus.in_data7;
  assign in_elem_s[7]  = bus.in_data8;
  assign in_elem_s[8]  = bus.in_data9;
  assign in_elem_s[9]  = bus.in_data10;
  assign in_elem_s[10] = bus.in_data11;
  assign in_elem_s[11] = bus.in_data12;

  // Next-state, index and capture decode; in_* only matter in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        idx_nxt_s = '0;
        if (bus.in_valid) begin
          capture_s   = 1'b1;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        // out_valid is always 1 in SEND, so out_ready alone accepts a beat.
        if (bus.out_ready) begin
          if (idx_r == SEL_W'(LAST_IDX)) begin
            idx_nxt_s   = '0;
            state_nxt_s = IDLE;
          end else begin
            idx_nxt_s   = idx_r + SEL_W'(1);
            state_nxt_s = SEND;
          end
        end else begin
          idx_nxt_s   = idx_r;
          state_nxt_s = SEND;
        end
      end
      default: begin
        idx_nxt_s   = '0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Frame bank: loaded only on capture, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        bank_r[i] <= '0;
      end
    end else if (capture_s) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        bank_r[i] <= in_elem_s[i];
      end
    end else begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        bank_r[i] <= bank_r[i];
      end
    end
  end

  mux12to1 #(
    .DATA_W (DATA_W)
  ) u_mux (
    .sel  (idx_r),
    .din  (bank_r),
    .dout (mux_data_s)
  );

  // Outputs decode purely from state/idx/bank so no in_* path reaches out_*.
  assign send_s        = (state_r == SEND);
  assign bus.in_ready  = ~send_s;
  assign bus.out_valid = send_s;
  assign bus.busy      = send_s;
  assign bus.out_sel   = send_s ? idx_r : '0;
  assign bus.out_data  = send_s ? mux_data_s : '0;
  assign bus.out_last  = send_s & (idx_r == SEL_W'(LAST_IDX));

endmodule

// File: tb/tb_mux_serializer12.sv
// ---------------------------------------------------------------------------
// tb_mux_serializer12
// Directed self-checking bench for mux_serializer12. Inputs change right
// after a falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mux_serializer12;
  import matrix_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mux_serializer12_if #(.DATA_W(8)) bus ();

  mux_serializer12 #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input logic [7:0] base);
    bus.in_data1  = base;
    bus.in_data2  = base + 8'd1;
    bus.in_data3  = base + 8'd2;
    bus.in_data4  = base + 8'd3;
    bus.in_data5  = base + 8'd4;
    bus.in_data6  = base + 8'd5;
    bus.in_data7  = base + 8'd6;
    bus.in_data8  = base + 8'd7;
    bus.in_data9  = base + 8'd8;
    bus.in_data10 = base + 8'd9;
    bus.in_data11 = base + 8'd10;
    bus.in_data12 = base + 8'd11;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, ".out_sel"},   32'(bus.out_sel),   32'd0);
    check({tag, ".out_data"},  32'(bus.out_data),  32'd0);
    check({tag, ".out_last"},  32'(bus.out_last),  32'd0);
    check({tag, ".busy"},      32'(bus.busy),      32'd0);
  endtask

  task automatic check_beat(input string tag, input int k, input logic [7:0] exp_data);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, ".busy"},      32'(bus.busy),      32'd1);
    check({tag, ".out_sel"},   32'(bus.out_sel),   32'(k));
    check({tag, ".out_data"},  32'(bus.out_data),  32'(exp_data));
    check({tag, ".out_last"},  32'(bus.out_last),  (k == 11) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_frame(8'h00);

    // Reset state, then release so the very next rising edge can capture.
    #2;
    check_idle("reset");
    @(negedge clk);
    check_idle("reset_hold");
    rst_n = 1'b1;

    // Single frame 01..0C with out_ready held high.
    set_frame(8'h01);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_beat("single", k, 8'h01 + 8'(k));
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    check_idle("single_end");

    // Backpressure: stall three cycles while element 5 is presented.
    set_frame(8'h01);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_beat("bp_pre", k, 8'h01 + 8'(k));
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_beat("bp_hold", 5, 8'h06);
    end
    bus.out_ready = 1'b1;
    for (int k = 6; k < 12; k++) begin
      @(negedge clk);
      check_beat("bp_post", k, 8'h01 + 8'(k));
    end
    @(negedge clk);
    check_idle("bp_end");

    // in_* ignored during SEND; in_valid held high gives back-to-back frames.
    set_frame(8'h01);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_beat("ign", k, 8'h01 + 8'(k));
      if (k == 3) begin
        bus.in_data1  = 8'hFF; bus.in_data2  = 8'hFF; bus.in_data3  = 8'hFF;
        bus.in_data4  = 8'hFF; bus.in_data5  = 8'hFF; bus.in_data6  = 8'hFF;
        bus.in_data7  = 8'hFF; bus.in_data8  = 8'hFF; bus.in_data9  = 8'hFF;
        bus.in_data10 = 8'hFF; bus.in_data11 = 8'hFF; bus.in_data12 = 8'hFF;
      end
    end
    @(negedge clk);
    check_idle("b2b_bubble");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_beat("b2b_next", k, 8'hFF);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    check_idle("b2b_end");

    // Reset mid-frame at element 7, held for two rising edges.
    set_frame(8'h01);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_beat("rst_pre", k, 8'h01 + 8'(k));
      bus.in_valid = 1'b0;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    check_idle("rst_low1");
    @(negedge clk);
    check_idle("rst_low2");
    rst_n = 1'b1;
    set_frame(8'hA0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_beat("rst_new", k, 8'hA0 + 8'(k));
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    check_idle("rst_end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux_serializer12.md
MUX_SERIALIZER12 -- requirements
Module: mux_serializer12

Interface
REQ-001 Parameter DATA_W, default 8, element width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  a 12-element frame is presented on in_data1..in_data12.
REQ-005 in_ready  output  1  block can capture a frame.
REQ-006 in_data1..in_data12  input  DATA_W each  frame elements; element k carries select index k-1.
REQ-007 out_valid  output  1  out_data and out_sel are valid.
REQ-008 out_ready  input  1  downstream accepts the current element.
REQ-009 out_data  output  DATA_W  current element.
REQ-010 out_sel  output  4  element index, 4'b0000..4'b1011 (0..11).
REQ-011 out_last  output  1  current element is index 11.
REQ-012 busy  output  1  a frame is being streamed (state SEND).

Function
REQ-013 The FSM SHALL have two states: IDLE and SEND.
REQ-014 IDLE: in_ready=1, out_valid=0, out_last=0, out_data=0, out_sel=0.
REQ-015 IDLE and in_valid=1: on that edge, capture all 12 elements into an internal bank, set idx=0, go to SEND.
REQ-016 SEND: in_ready=0, out_valid=1, out_sel=idx, out_data=bank[idx], out_last=(idx==11).
REQ-017 Beat accepted when out_valid & out_ready on a rising edge; idx<11 -> idx+1; idx==11 -> idx=0, go to IDLE.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_sel and out_last SHALL hold their values.
REQ-019 in_valid and in_data* SHALL be ignored in SEND; the bank changes only on capture.
REQ-020 Latency: first element valid the cycle after capture; with out_ready held high, 12 elements on 12 consecutive cycles.
REQ-021 in_ready returns to 1 the cycle after the last beat is accepted (one-cycle bubble between frames; no overlap).
REQ-022 idx SHALL never exceed 11; indices 12..15 are never driven on out_sel.
REQ-023 Outputs SHALL be driven from registers (state, idx, bank) through the select mux only; in_* SHALL have no combinational path to out_*.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force IDLE, idx=0, bank all zero, out_valid=0, out_last=0, busy=0, in_ready=1, out_data=0, out_sel=0.
REQ-025 A reset mid-frame SHALL abandon that frame; no remaining element is emitted after reset is released.
REQ-026 The first capture SHALL be possible on the first rising edge with rst_n=1.

Structure
REQ-027 Shared package matrix_pkg SHALL hold ELEM_W=8, NUM_ELEM=12, SEL_W=4, LAST_IDX=11 and the IDLE/SEND state enum.
REQ-028 Element selection SHALL be one sub-module, mux12to1 (combinational, 4-bit select, 12 x DATA_W inputs); FSM, index counter and bank stay in mux_serializer12.

Verification
REQ-029 Reset: rst_n=0 mid-simulation, asynchronously -> same cycle out_valid=0, in_ready=1, out_sel=0, out_data=0.
REQ-030 Single frame, out_ready=1: in_data1..12=8'h01..8'h0C -> out_sel 0..11 / out_data 8'h01..8'h0C on 12 consecutive cycles; out_last only with 8'h0C; in_ready=1 on the next cycle.
REQ-031 Backpressure: out_ready=0 for 3 cycles at out_sel=5 -> out_data holds 8'h06 and out_sel holds 5 for 4 cycles total; stream then resumes at 6.
REQ-032 Ignore during SEND: change in_data* to 8'hFF and hold in_valid=1 mid-frame -> remaining elements still 8'h01..8'h0C; the next frame is captured only after return to IDLE.
REQ-033 Reset mid-frame: rst_n=0 at out_sel=7 for 2 cycles, then in_valid with 8'hA0..8'hAB -> stream restarts at out_sel=0 with 8'hA0; no 8'h08..8'h0C emitted.
REQ-034 Back-to-back frames, in_valid held high, out_ready=1 -> exactly one idle cycle (out_valid=0) between the out_last beat and out_sel=0 of the next frame.
